// File: rtl/namco_wsg3_seq_if.sv
// CPU register-write port, wave ROM port and PCM output of the WSG3 sequencer.
interface namco_wsg3_seq_if;
  logic [4:0] AD;
  logic [3:0] DI;
  logic       WR;
  logic [7:0] WAVEAD;
  logic [3:0] WAVEDT;
  logic       PCMCLK;
  logic [7:0] PCMOUT;

  modport master (output AD, DI, WR, WAVEDT, input WAVEAD, PCMCLK, PCMOUT);
  modport slave  (input AD, DI, WR, WAVEDT, output WAVEAD, PCMCLK, PCMOUT);
endinterface

// File: rtl/namco_wsg3_seq.sv
// Three-voice Namco WSG3: phase accumulators, wave ROM fetch, volume MAC and
// 8-bit PCM output, sequenced once per CLK_DIV clocks.
module namco_wsg3_voice (
  input  logic       CL,
  input  logic       RESET,
  input  logic       i_add,
  input  logic       i_acc_we,
  input  logic       i_freq_we,
  input  logic       i_vol_we,
  input  logic       i_wave_we,
  input  logic [2:0] i_nib,
  input  logic [3:0] i_di,
  output logic [4:0] o_ph,
  output logic [3:0] o_vol,
  output logic [2:0] o_wave
);
  logic [19:0] r_acc, r_freq, w_acc_nxt, w_freq_nxt;
  logic [3:0]  r_vol;
  logic [2:0]  r_wave;

  // A CPU nibble write lands on top of the accumulate result in the same cycle.
  always_comb begin
    w_acc_nxt  = i_add ? r_acc + r_freq : r_acc;
    w_freq_nxt = r_freq;
    for (int n = 0; n < 5; n++) begin
      if (i_acc_we  && i_nib == 3'(n)) w_acc_nxt[4*n +: 4]  = i_di;
      if (i_freq_we && i_nib == 3'(n)) w_freq_nxt[4*n +: 4] = i_di;
    end
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      r_acc  <= '0;
      r_freq <= '0;
      r_vol  <= '0;
      r_wave <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_freq <= w_freq_nxt;
      if (i_vol_we)  r_vol  <= i_di;
      if (i_wave_we) r_wave <= i_di[2:0];
    end
  end

  assign o_ph   = r_acc[19:15];
  assign o_vol  = r_vol;
  assign o_wave = r_wave;
endmodule

module namco_wsg3_seq #(
  parameter int CLK_DIV = 250
) (
  input  logic             CL,
  input  logic             RESET,
  namco_wsg3_seq_if.slave  bus
);
  localparam int NUM_VOICES = 3;
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADD0, S_ADR0, S_WAIT0, S_MAC0,
    S_ADD1, S_ADR1, S_WAIT1, S_MAC1,
    S_ADD2, S_ADR2, S_WAIT2, S_MAC2,
    S_OUT
  } state_t;

  state_t r_state, w_nxt;
  logic [11:0] r_div;
  logic        w_tick;
  logic [9:0]  r_sum;
  logic [7:0]  r_wavead, r_pcmout, w_prod;
  logic        r_pcmclk;
  logic [NUM_VOICES-1:0]      w_add;
  logic                       w_adr, w_mac, w_out, w_clr;
  logic [1:0]                 w_v;
  logic [NUM_VOICES-1:0][4:0] w_ph;
  logic [NUM_VOICES-1:0][3:0] w_vol;
  logic [NUM_VOICES-1:0][2:0] w_wave;
  logic [3:0] w_lo;
  logic [1:0] w_wv;
  logic [2:0] w_wn;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) r_div <= '0;
    else       r_div <= w_tick ? 12'd0 : r_div + 12'd1;
  end

  // Address low nibble -> voice and nibble slot; slot 5 is WAVE (AD[4]=0) or VOL (AD[4]=1).
  assign w_lo = bus.AD[3:0];
  always_comb begin
    w_wv = 2'd0;
    w_wn = 3'(w_lo);
    if (w_lo >= 4'd11) begin
      w_wv = 2'd2;
      w_wn = 3'(w_lo - 4'd10);
    end else if (w_lo >= 4'd6) begin
      w_wv = 2'd1;
      w_wn = 3'(w_lo - 4'd5);
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic w_hit;
    assign w_hit = bus.WR && (w_wv == 2'(g));
    namco_wsg3_voice u_voice (
      .CL        (CL),
      .RESET     (RESET),
      .i_add     (w_add[g]),
      .i_acc_we  (w_hit && !bus.AD[4] && w_wn != 3'd5),
      .i_freq_we (w_hit &&  bus.AD[4] && w_wn != 3'd5),
      .i_vol_we  (w_hit &&  bus.AD[4] && w_wn == 3'd5),
      .i_wave_we (w_hit && !bus.AD[4] && w_wn == 3'd5),
      .i_nib     (w_wn),
      .i_di      (bus.DI),
      .o_ph      (w_ph[g]),
      .o_vol     (w_vol[g]),
      .o_wave    (w_wave[g])
    );
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    w_add = '0;
    w_adr = 1'b0;
    w_mac = 1'b0;
    w_out = 1'b0;
    w_clr = 1'b0;
    w_v   = 2'd0;
    case (r_state)
      S_IDLE:  if (w_tick) begin w_clr = 1'b1; w_nxt = S_ADD0; end
      S_ADD0:  begin w_add[0] = 1'b1; w_nxt = S_ADR0; end
      S_ADR0:  begin w_adr = 1'b1; w_v = 2'd0; w_nxt = S_WAIT0; end
      S_WAIT0: w_nxt = S_MAC0;
      S_MAC0:  begin w_mac = 1'b1; w_v = 2'd0; w_nxt = S_ADD1; end
      S_ADD1:  begin w_add[1] = 1'b1; w_nxt = S_ADR1; end
      S_ADR1:  begin w_adr = 1'b1; w_v = 2'd1; w_nxt = S_WAIT1; end
      S_WAIT1: w_nxt = S_MAC1;
      S_MAC1:  begin w_mac = 1'b1; w_v = 2'd1; w_nxt = S_ADD2; end
      S_ADD2:  begin w_add[2] = 1'b1; w_nxt = S_ADR2; end
      S_ADR2:  begin w_adr = 1'b1; w_v = 2'd2; w_nxt = S_WAIT2; end
      S_WAIT2: w_nxt = S_MAC2;
      S_MAC2:  begin w_mac = 1'b1; w_v = 2'd2; w_nxt = S_OUT; end
      S_OUT:   begin w_out = 1'b1; w_nxt = S_IDLE; end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_prod = {4'h0, bus.WAVEDT} * {4'h0, w_vol[w_v]};

  // PCMCLK is registered alongside PCMOUT so the strobe marks the new value.
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      r_sum    <= '0;
      r_wavead <= '0;
      r_pcmout <= '0;
      r_pcmclk <= 1'b0;
    end else begin
      r_pcmclk <= w_out;
      if (w_clr)      r_sum <= '0;
      else if (w_mac) r_sum <= r_sum + {2'b00, w_prod};
      if (w_adr) r_wavead <= {w_wave[w_v], w_ph[w_v]};
      if (w_out) r_pcmout <= r_sum[9:2];
    end
  end

  assign bus.WAVEAD = r_wavead;
  assign bus.PCMOUT = r_pcmout;
  assign bus.PCMCLK = r_pcmclk;
endmodule

// File: doc/namco_wsg3_seq.md
Name: namco_wsg3_seq

Overview:
- Single-clock, three-voice Namco wavetable sound generator. Sits downstream of the I/O-device address decode and consumes the CPU's 4-bit register writes at $6800-$681F.
- Fetches 4-bit samples from the external 256x4 wave ROM, scales each by its voice volume, and sums the three voices.
- Emits an 8-bit unsigned PCM sample plus a one-cycle strobe at the configured sample rate.

Parameters:
- CLK_DIV, 250, CL cycles per output sample (250 gives 96 kHz at 24 MHz). Legal range 16..4095.

Ports:
- CL  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- AD  in  5  register address, CPU AD[4:0].
- DI  in  4  register write data, CPU DI[3:0].
- WR  in  1  register write strobe, already qualified by the $6800-$681F decode. Sampled on CL rising edge.
- WAVEAD  out  8  wave ROM address, registered.
- WAVEDT  in  4  wave ROM data.
- PCMCLK  out  1  one-cycle strobe; high in the cycle PCMOUT takes a new value.
- PCMOUT  out  8  unsigned mixed sample, registered.

Behaviour:
- Clocking and reset:
  - Single clock CL. RESET is asynchronous, active-high.
  - Reset clears all registers, the divider, the sum, WAVEAD=0x00, PCMOUT=0x00, PCMCLK=0, and puts the FSM in IDLE.
  - RESET asserted mid-sequence aborts immediately; there is no partial output.
- Register map (nibble-wide, write-only, reads not supported):
  - 0x00-0x04: ACC0 nibbles 0..4 (LSN first).
  - 0x05: WAVE0 (bits [2:0] used).
  - 0x06-0x09: ACC1 nibbles 1..4.
  - 0x0A: WAVE1.
  - 0x0B-0x0E: ACC2 nibbles 1..4.
  - 0x0F: WAVE2.
  - 0x10-0x14: FREQ0 nibbles 0..4.
  - 0x15: VOL0.
  - 0x16-0x19: FREQ1 nibbles 1..4.
  - 0x1A: VOL1.
  - 0x1B-0x1E: FREQ2 nibbles 1..4.
  - 0x1F: VOL2.
  - Accumulators and frequencies are 20 bits. Nibble 0 of ACC1/ACC2/FREQ1/FREQ2 is hardwired 0.
  - A write takes effect on the CL edge where WR=1.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps. TICK is asserted when the count equals CLK_DIV-1.
  - The first TICK occurs CLK_DIV cycles after reset release.
- FSM:
  - States: IDLE, then for v=0,1,2 the states ADD_v, ADR_v, WAIT_v, MAC_v, then OUT, then back to IDLE. 13 cycles per sample.
  - IDLE: on TICK, clear sum to 0 and go to ADD_0.
  - ADD_v: ACCv <= (ACCv + FREQv) mod 2^20. Wraps silently.
  - ADR_v: WAVEAD <= {WAVEv[2:0], ACCv[19:15]}, using the updated ACCv.
  - WAIT_v: ROM latency cycle. The ROM is synchronous, and data is valid the cycle after it samples the address.
  - MAC_v: sum <= sum + WAVEDT*VOLv. Product is 8 bits; sum is 10 bits, max 675, so it never overflows.
  - OUT: PCMOUT <= sum[9:2]; PCMCLK=1 for this cycle only.
  - PCMOUT holds its value between strobes.
- Collisions:
  - A CPU write to an ACCv nibble in the same cycle as ADD_v: the CPU nibble overrides that nibble of the sum result, and the other nibbles take the sum.
  - A write to FREQv, VOLv or WAVEv during a sequence affects that voice only if written before the state that uses it.
- Boundaries:
  - FREQ=0 holds the phase.
  - VOL=0 contributes 0.
  - A TICK arriving while not in IDLE cannot happen (CLK_DIV >= 16). No sample is skipped.
  - Out-of-range bits (AD values are all mapped) need no handling.

Test Plan:
1. Reset: assert RESET mid-sequence (state MAC_1) -> PCMOUT=0x00, PCMCLK=0, WAVEAD=0x00 within the same cycle. After release, the first PCMCLK comes exactly CLK_DIV+13 cycles later.
2. Single voice: FREQ0=0x08000, WAVE0=2, VOL0=0xF, ROM returns addr[3:0]. First sample: WAVEAD=0x41, PCMOUT=(1*15)>>2=0x03. Second sample: WAVEAD=0x42, PCMOUT=0x07.
3. Full-scale mix: ROM returns 0xF, VOL0..2=0xF, all FREQ nonzero -> PCMOUT=0xA8 (675>>2). Set VOL1=0 -> PCMOUT=0x70.
4. Wrap: write ACC0=0xFFFFF, FREQ0=0x00001 -> after one sample ACC0=0x00000, WAVEAD low 5 bits=0x00.
5. Collision: write AD=0x04 DI=0x3 exactly in the ADD_0 cycle with ACC0=0x00000, FREQ0=0x10000 -> ACC0=0x30000, WAVEAD=0x06 (WAVE0=0).
6. Rate: CLK_DIV=16 -> PCMCLK period exactly 16 cycles and high for exactly 1 cycle, over 100 samples.
